// File: rtl/scaler_vout_pkg.sv
// Shared scaler definitions: log2 helper, pixel bus defaults, output FSM encoding.
package scaler_vout_pkg;

  // Ceiling log2 for sizing counters and pointers at elaboration time.
  function automatic int unsigned CLOG2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  localparam int unsigned PIXEL_BITWIDTH_DFLT = 8;
  localparam int unsigned PIXEL_NUM_DFLT      = 2;
  localparam int unsigned PIXEL_BUS_W         = PIXEL_BITWIDTH_DFLT * PIXEL_NUM_DFLT;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONNECT = 3'd1,
    ST_LINE    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/scaler_vout_fifo.sv
// Single-clock line FIFO with registered read data; DEPTH must be a power of two.
module scaler_vout_fifo
  import scaler_vout_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned WIDTH = PIXEL_BUS_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [CLOG2(DEPTH):0]     count
);

  localparam int unsigned AW = CLOG2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             wr_ok, rd_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rd_data = rd_data_q;
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q] <= wr_data;
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (rd_ok) begin
        rptr_q    <= rptr_q + AW'(1);
        rd_data_q <= mem[rptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/scaler_vout.sv
// Line-credit core stream to framed AXI4-Stream video with backpressure and done pulse.
module scaler_vout
  import scaler_vout_pkg::*;
#(
  parameter int unsigned PIXEL_BITWIDTH = PIXEL_BITWIDTH_DFLT,
  parameter int unsigned PIXEL_NUM      = PIXEL_NUM_DFLT,
  parameter int unsigned IMG_H_MAX      = 3840,
  parameter int unsigned IMG_V_MAX      = 2160,
  parameter int unsigned IMG_H_BITWIDTH = CLOG2(IMG_H_MAX),
  parameter int unsigned IMG_V_BITWIDTH = CLOG2(IMG_V_MAX),
  parameter int unsigned FIFO_DEPTH     = 4096
) (
  input  logic                                s_clk,
  input  logic                                s_rst_n,
  input  logic                                s_start,
  input  logic [IMG_H_BITWIDTH-1:0]           s_arg_img_dst_h,
  input  logic [IMG_V_BITWIDTH-1:0]           s_arg_img_dst_v,
  input  logic                                s_axis_connect_valid,
  output logic                                s_axis_connect_ready,
  input  logic                                s_axis_img_valid,
  input  logic [PIXEL_BITWIDTH*PIXEL_NUM-1:0] s_axis_img_pixel,
  input  logic                                m_axis_ready,
  output logic                                m_axis_valid,
  output logic [PIXEL_BITWIDTH*PIXEL_NUM-1:0] m_axis_pixel,
  output logic                                m_axis_sof,
  output logic                                m_axis_eol,
  output logic                                m_done,
  output logic                                m_err_overflow
);

  localparam int unsigned PIX_W = PIXEL_BITWIDTH * PIXEL_NUM;
  localparam int unsigned HW    = IMG_H_BITWIDTH;
  localparam int unsigned VW    = IMG_V_BITWIDTH;
  localparam int unsigned CNT_W = CLOG2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = ((CNT_W > HW) ? CNT_W : HW) + 2;

  state_e           state_q;
  logic [HW-1:0]    arg_h_q, in_h_q, out_h_q;
  logic [VW-1:0]    arg_v_q, in_v_q, out_v_q;
  logic             conn_rdy_q, done_q, err_q, stage_v_q;
  logic             m_valid_q, m_sof_q, m_eol_q;
  logic [PIX_W-1:0] m_pixel_q;

  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [PIX_W-1:0] fifo_rd_data;

  logic start_ok, args_zero, conn_hs, wr_en, rd_en, drop;
  logic line_end, frame_end, slot_load, credit_ok, drain_done;
  logic [OCC_W-1:0] occ_req;

  assign start_ok  = (state_q == ST_IDLE) && s_start;
  assign args_zero = (s_arg_img_dst_h == '0) || (s_arg_img_dst_v == '0);
  assign conn_hs   = s_axis_connect_valid && conn_rdy_q;
  assign wr_en     = s_axis_img_valid && (state_q == ST_LINE) && !fifo_full;
  assign drop      = s_axis_img_valid && !wr_en;
  assign line_end  = wr_en && (in_h_q == arg_h_q - HW'(1));
  assign frame_end = line_end && (in_v_q == arg_v_q - VW'(1));

  // The fetched FIFO word waits in the read register (stage) until the slot can take it.
  assign slot_load  = stage_v_q && (!m_valid_q || m_axis_ready);
  assign rd_en      = !fifo_empty && (!stage_v_q || slot_load);
  assign drain_done = fifo_empty && !stage_v_q && (!m_valid_q || m_axis_ready);

  // Credit counts beats already pulled into the stage and slot so a granted line always fits.
  assign occ_req   = OCC_W'(fifo_count) + OCC_W'(stage_v_q) + OCC_W'(m_valid_q) + OCC_W'(arg_h_q);
  assign credit_ok = (occ_req <= OCC_W'(FIFO_DEPTH));

  scaler_vout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk     (s_clk),
    .rst_n   (s_rst_n),
    .wr_en   (wr_en),
    .wr_data (s_axis_img_pixel),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Frame FSM with argument latch, registered credit, done pulse and sticky overflow.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= ST_IDLE;
      arg_h_q    <= '0;
      arg_v_q    <= '0;
      conn_rdy_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      conn_rdy_q <= (state_q == ST_CONNECT) && !conn_hs && credit_ok;
      done_q     <= (state_q == ST_DONE);
      if (drop)          err_q <= 1'b1;
      else if (start_ok) err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s_start) begin
            arg_h_q <= s_arg_img_dst_h;
            arg_v_q <= s_arg_img_dst_v;
            state_q <= args_zero ? ST_DONE : ST_CONNECT;
          end
        end
        ST_CONNECT: if (conn_hs) state_q <= ST_LINE;
        ST_LINE:    if (line_end) state_q <= frame_end ? ST_DRAIN : ST_CONNECT;
        ST_DRAIN:   if (drain_done) state_q <= ST_DONE;
        ST_DONE:    state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  // Input beat/line counters.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      in_h_q <= '0;
      in_v_q <= '0;
    end else if (start_ok) begin
      in_h_q <= '0;
      in_v_q <= '0;
    end else if (wr_en) begin
      if (line_end) begin
        in_h_q <= '0;
        in_v_q <= frame_end ? '0 : in_v_q + VW'(1);
      end else begin
        in_h_q <= in_h_q + HW'(1);
      end
    end
  end

  // Stage valid tracks whether the FIFO read register holds an unconsumed beat.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n)       stage_v_q <= 1'b0;
    else if (rd_en)     stage_v_q <= 1'b1;
    else if (slot_load) stage_v_q <= 1'b0;
  end

  // Output slot with sof/eol framing counters; held while stalled.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      m_valid_q <= 1'b0;
      m_pixel_q <= '0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
      out_h_q   <= '0;
      out_v_q   <= '0;
    end else if (start_ok) begin
      out_h_q <= '0;
      out_v_q <= '0;
    end else if (slot_load) begin
      m_valid_q <= 1'b1;
      m_pixel_q <= fifo_rd_data;
      m_sof_q   <= (out_h_q == '0) && (out_v_q == '0);
      m_eol_q   <= (out_h_q == arg_h_q - HW'(1));
      if (out_h_q == arg_h_q - HW'(1)) begin
        out_h_q <= '0;
        out_v_q <= (out_v_q == arg_v_q - VW'(1)) ? '0 : out_v_q + VW'(1);
      end else begin
        out_h_q <= out_h_q + HW'(1);
      end
    end else if (m_valid_q && m_axis_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign s_axis_connect_ready = conn_rdy_q;
  assign m_axis_valid         = m_valid_q;
  assign m_axis_pixel         = m_pixel_q;
  assign m_axis_sof           = m_sof_q;
  assign m_axis_eol           = m_eol_q;
  assign m_done               = done_q;
  assign m_err_overflow       = err_q;

endmodule
